// File: rtl/reg_bank_pkg.sv
// Shared state type and width constants for the register-bank request/response front end.
package reg_bank_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned STROBE_W   = 1;
    localparam int unsigned WR_COUNT_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

endpackage

// File: rtl/reg_addr_decoder.sv
// Combinational register-index decoder: one-hot select plus an in-range flag.
module reg_addr_decoder
    import reg_bank_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot,
    output logic                in_range
);

    localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            onehot[i] = (addr == ADDR_W'(i));
        end
        in_range = ({1'b0, addr} < NumRegsW);
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Request/response front end driving a bank of register cells with registered, glitch-free strobes.
// Optional REG_BANK_CTRL_ERR_EN adds resp_err (out-of-range flag) and an 8-bit write counter.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_rdata,
`ifdef REG_BANK_CTRL_ERR_EN
    output logic                       resp_err,
    output logic [WR_COUNT_W-1:0]      wr_count,
`endif
    output logic [NUM_REGS-1:0]        reg_cs,
    output logic [STROBE_W-1:0]        reg_w,
    output logic [STROBE_W-1:0]        reg_r,
    output logic [DATA_W-1:0]          reg_din,
    input  logic [NUM_REGS*DATA_W-1:0] reg_dout
);

    state_e              state_q, state_d;
    logic [NUM_REGS-1:0] reg_cs_q, reg_cs_d;
    logic [STROBE_W-1:0] reg_w_q, reg_w_d;
    logic [STROBE_W-1:0] reg_r_q, reg_r_d;
    logic [DATA_W-1:0]   reg_din_q, reg_din_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic [NUM_REGS-1:0] dec_onehot;
    logic                dec_in_range;
    logic [DATA_W-1:0]   rd_slice;
`ifdef REG_BANK_CTRL_ERR_EN
    logic                  in_range_q, in_range_d;
    logic                  resp_err_q, resp_err_d;
    logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
`endif

    reg_addr_decoder #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .addr     (req_addr),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    // Select by the registered chip-select so unselected (undefined) slices never reach the mux.
    always_comb begin
        rd_slice = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (reg_cs_q[i]) begin
                rd_slice = reg_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        reg_cs_d     = reg_cs_q;
        reg_w_d      = reg_w_q;
        reg_r_d      = reg_r_q;
        reg_din_d    = reg_din_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
`ifdef REG_BANK_CTRL_ERR_EN
        in_range_d   = in_range_q;
        resp_err_d   = resp_err_q;
        wr_count_d   = wr_count_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    reg_cs_d  = dec_onehot & {NUM_REGS{dec_in_range}};
                    reg_w_d   = {STROBE_W{req_we & dec_in_range}};
                    reg_r_d   = {STROBE_W{~req_we & dec_in_range}};
                    reg_din_d = req_wdata;
`ifdef REG_BANK_CTRL_ERR_EN
                    in_range_d = dec_in_range;
`endif
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                resp_rdata_d = (|reg_r_q) ? rd_slice : '0;
`ifdef REG_BANK_CTRL_ERR_EN
                resp_err_d   = ~in_range_q;
                if (|reg_w_q) begin
                    wr_count_d = wr_count_q + WR_COUNT_W'(1);
                end
`endif
                reg_cs_d     = '0;
                reg_w_d      = '0;
                reg_r_d      = '0;
                reg_din_d    = '0;
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
`ifdef REG_BANK_CTRL_ERR_EN
                    resp_err_d   = 1'b0;
`endif
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            reg_cs_q     <= '0;
            reg_w_q      <= '0;
            reg_r_q      <= '0;
            reg_din_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
`ifdef REG_BANK_CTRL_ERR_EN
            in_range_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            wr_count_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            reg_cs_q     <= reg_cs_d;
            reg_w_q      <= reg_w_d;
            reg_r_q      <= reg_r_d;
            reg_din_q    <= reg_din_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef REG_BANK_CTRL_ERR_EN
            in_range_q   <= in_range_d;
            resp_err_q   <= resp_err_d;
            wr_count_q   <= wr_count_d;
`endif
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign reg_cs     = reg_cs_q;
    assign reg_w      = reg_w_q;
    assign reg_r      = reg_r_q;
    assign reg_din    = reg_din_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
`ifdef REG_BANK_CTRL_ERR_EN
    assign resp_err   = resp_err_q;
    assign wr_count   = wr_count_q;
`endif

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl (6-register bank) with a behavioural register-array model.
module tb_reg_bank_ctrl;

    localparam int unsigned NREGS = 6;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int          NV    = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic              resp_valid, resp_ready;
    logic [DW-1:0]     resp_rdata;
    logic [NREGS-1:0]  reg_cs;
    logic              reg_w, reg_r;
    logic [DW-1:0]     reg_din;
    logic [NREGS*DW-1:0] reg_dout;
`ifdef REG_BANK_CTRL_ERR_EN
    logic              resp_err;
    logic [7:0]        wr_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [NREGS];

    always #5 clk = ~clk;

    reg_bank_ctrl #(
        .NUM_REGS (NREGS),
        .DATA_W   (DW),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
`ifdef REG_BANK_CTRL_ERR_EN
        .resp_err   (resp_err),
        .wr_count   (wr_count),
`endif
        .reg_cs     (reg_cs),
        .reg_w      (reg_w),
        .reg_r      (reg_r),
        .reg_din    (reg_din),
        .reg_dout   (reg_dout)
    );

    // Register array: commits writes on the edge, drives X on every slice not read-selected.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (reg_w) begin
            for (int i = 0; i < NREGS; i++) if (reg_cs[i]) mem[i] <= reg_din;
        end
    end

    always_comb begin
        reg_dout = 'x;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_cs[i] && reg_r) reg_dout[i*DW +: DW] = mem[i];
        end
    end

    typedef struct {
        logic             we;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    wdata;
        logic [NREGS-1:0] exp_cs;
        logic             exp_w;
        logic             exp_r;
        logic [DW-1:0]    exp_rdata;
        logic             exp_err;
    } vec_t;

    vec_t vec [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, 32'(req_ready), 32'd1);
    endtask

    // Present a request in an idle cycle; returns #1 after the accepting edge (ACCESS cycle).
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        wait_ready("req_ready_before_issue");
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec[0] = '{1'b1, 3'd3, 16'hA5C3, 6'b001000, 1'b1, 1'b0, 16'h0000, 1'b0};
        vec[1] = '{1'b0, 3'd3, 16'h0000, 6'b001000, 1'b0, 1'b1, 16'hA5C3, 1'b0};
        vec[2] = '{1'b1, 3'd0, 16'h1234, 6'b000001, 1'b1, 1'b0, 16'h0000, 1'b0};
        vec[3] = '{1'b1, 3'd5, 16'hBEEF, 6'b100000, 1'b1, 1'b0, 16'h0000, 1'b0};
        vec[4] = '{1'b0, 3'd0, 16'h0000, 6'b000001, 1'b0, 1'b1, 16'h1234, 1'b0};
        vec[5] = '{1'b0, 3'd5, 16'h0000, 6'b100000, 1'b0, 1'b1, 16'hBEEF, 1'b0};
        vec[6] = '{1'b0, 3'd7, 16'h0000, 6'b000000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vec[7] = '{1'b1, 3'd6, 16'hDEAD, 6'b000000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vec[8] = '{1'b0, 3'd1, 16'h0000, 6'b000010, 1'b0, 1'b1, 16'h0000, 1'b0};
        vec[9] = '{1'b0, 3'd3, 16'h0000, 6'b001000, 1'b0, 1'b1, 16'hA5C3, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cs", 32'(reg_cs), 32'd0);
        check("rst_w", 32'(reg_w), 32'd0);
        check("rst_r", 32'(reg_r), 32'd0);
        check("rst_din", 32'(reg_din), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", 32'(resp_rdata), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            issue(vec[i].we, vec[i].addr, vec[i].wdata);
            check($sformatf("v%0d_cs", i), 32'(reg_cs), 32'(vec[i].exp_cs));
            check($sformatf("v%0d_w", i), 32'(reg_w), 32'(vec[i].exp_w));
            check($sformatf("v%0d_r", i), 32'(reg_r), 32'(vec[i].exp_r));
            check($sformatf("v%0d_din", i), 32'(reg_din), 32'(vec[i].wdata));
            check($sformatf("v%0d_busy", i), 32'(req_ready), 32'd0);
            check($sformatf("v%0d_early_valid", i), 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'd1);
            check($sformatf("v%0d_rdata", i), 32'(resp_rdata), 32'(vec[i].exp_rdata));
            check($sformatf("v%0d_strobes_off", i), 32'({reg_cs, reg_w, reg_r}), 32'd0);
`ifdef REG_BANK_CTRL_ERR_EN
            check($sformatf("v%0d_err", i), 32'(resp_err), 32'(vec[i].exp_err));
`endif
            @(posedge clk); #1;
            check($sformatf("v%0d_resp_done", i), 32'(resp_valid), 32'd0);
            check($sformatf("v%0d_ready_again", i), 32'(req_ready), 32'd1);
        end

        // Stalled response: output held, new request ignored while busy.
        resp_ready = 1'b0;
        issue(1'b0, 3'd0, 16'h0000);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 16'hFFFF;
        for (int j = 0; j < 5; j++) begin
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_rdata", 32'(resp_rdata), 32'h1234);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_no_strobe", 32'({reg_cs, reg_w, reg_r}), 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_released", 32'(resp_valid), 32'd0);
        check("stall_idle", 32'(req_ready), 32'd1);
        check("stall_not_accepted", 32'(reg_cs), 32'd0);
        issue(1'b0, 3'd1, 16'h0000);
        @(posedge clk); #1;
        check("stall_reg1_untouched", 32'(resp_rdata), 32'd0);
        @(posedge clk); #1;

        // Back-to-back reads with resp_ready tied high: one transaction every 3 cycles.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd5; req_wdata = '0;
        @(posedge clk); #1;
        for (int j = 0; j < 9; j++) begin
            check("b2b_r", 32'(reg_r), 32'((j % 3) == 0));
            check("b2b_cs", 32'(reg_cs), ((j % 3) == 0) ? 32'b100000 : 32'd0);
            check("b2b_valid", 32'(resp_valid), 32'((j % 3) == 1));
            if ((j % 3) == 1) check("b2b_rdata", 32'(resp_rdata), 32'hBEEF);
            if (j == 8) req_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("b2b_stopped", 32'(reg_r), 32'd0);

        // Reset in the middle of ACCESS drops strobes without waiting for a clock edge.
        issue(1'b1, 3'd2, 16'h5555);
        check("midacc_w_before", 32'(reg_w), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midacc_cs", 32'(reg_cs), 32'd0);
        check("midacc_w", 32'(reg_w), 32'd0);
        check("midacc_din", 32'(reg_din), 32'd0);
        check("midacc_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("midacc_no_resp", 32'(resp_valid), 32'd0);

        // Reset during RESP discards the pending response.
        resp_ready = 1'b0;
        issue(1'b0, 3'd0, 16'h0000);
        @(posedge clk); #1;
        check("midresp_valid_before", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midresp_valid", 32'(resp_valid), 32'd0);
        check("midresp_rdata", 32'(resp_rdata), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("midresp_idle", 32'(req_ready), 32'd1);
        check("midresp_still_quiet", 32'(resp_valid), 32'd0);

`ifdef REG_BANK_CTRL_ERR_EN
        check("wrcnt_reset", 32'(wr_count), 32'd0);
        for (int n = 0; n < 300; n++) begin
            issue(1'b1, 3'd2, 16'(n));
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        check("wrcnt_300", 32'(wr_count), 32'd44);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
